// File: rtl/seq_pkg.sv
// Shared types, default parameters and helper functions for the serial pattern transmitter.
package seq_pkg;

  localparam int SEQ_WIDTH = 8;
  localparam int SEQ_CNT_W = 4;
  localparam int SEQ_GAP   = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } seq_tx_state_t;

  // A zero or oversized request length means "send the whole word".
  function automatic int seq_sat_len(input int len, input int width);
    if ((len == 0) || (len > width)) begin
      return width;
    end else begin
      return len;
    end
  endfunction

  function automatic logic seq_even_par(input logic [31:0] value);
    return ^value;
  endfunction

endpackage

// File: rtl/seq_shift_reg.sv
// Loadable left-shift register with a bit-index down-counter; msb is the bit on the line.
module seq_shift_reg #(
  parameter int SW    = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [SW-1:0]    load_data,
  input  logic [IDX_W-1:0] load_cnt,
  output logic             msb,
  output logic             last
);

  logic [SW-1:0]    data_r;
  logic [IDX_W-1:0] cnt_r;

  // Shift state; shifting past the final bit leaves the register all zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_r <= '0;
      cnt_r  <= '0;
    end else if (load) begin
      data_r <= load_data;
      cnt_r  <= load_cnt;
    end else if (shift) begin
      data_r <= {data_r[SW-2:0], 1'b0};
      cnt_r  <= (cnt_r != '0) ? (cnt_r - IDX_W'(1)) : cnt_r;
    end
  end

  assign msb  = data_r[SW-1];
  assign last = (cnt_r == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: MSB-first shift-out with optional repeats and zero gaps.
// Define SEQ_PATTERN_TX_PARITY_EN to append an even-parity bit to every copy.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH,
  parameter int CNT_W = SEQ_CNT_W,
  parameter int GAP   = SEQ_GAP
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [WIDTH-1:0]      load_pattern,
  input  logic [$clog2(WIDTH):0] load_len,
  input  logic [CNT_W-1:0]      load_rep,
  output logic                  ser_out,
  output logic                  ser_valid,
  output logic                  busy,
  output logic                  done
);

`ifdef SEQ_PATTERN_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int SW    = WIDTH + PAR;
  localparam int IDX_W = $clog2(SW);
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  seq_tx_state_t    state_r, state_s;
  logic [CNT_W-1:0] rep_r, rep_s;
  logic [GAP_W-1:0] gap_r, gap_s;
  logic [SW-1:0]    pat_r, pat_s;
  logic [IDX_W-1:0] cnt_r, cnt_s;

  int               eff_len_s;
  int               copy_len_s;
  logic [WIDTH-1:0] masked_s;
  logic [SW-1:0]    base_s;
  logic [SW-1:0]    word_s;
  logic [IDX_W-1:0] word_cnt_s;

  logic             sh_load_s, sh_shift_s;
  logic [SW-1:0]    sh_data_s;
  logic [IDX_W-1:0] sh_cnt_s;
  logic             sh_msb_s, sh_last_s;

  logic             load_ready_r, ser_valid_r, busy_r, done_r;

  // Build the copy image left-aligned so its first bit sits at the register MSB.
  always_comb begin
    eff_len_s = seq_sat_len(32'(load_len), WIDTH);
    masked_s  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      masked_s[i] = load_pattern[i] & (i < eff_len_s);
    end
`ifdef SEQ_PATTERN_TX_PARITY_EN
    base_s = {masked_s, seq_even_par(32'(masked_s))};
`else
    base_s = masked_s;
`endif
    copy_len_s = eff_len_s + PAR;
    word_s     = base_s << (SW - copy_len_s);
    word_cnt_s = IDX_W'(copy_len_s - 1);
  end

  // Next-state and datapath control.
  always_comb begin
    state_s    = state_r;
    rep_s      = rep_r;
    gap_s      = gap_r;
    pat_s      = pat_r;
    cnt_s      = cnt_r;
    sh_load_s  = 1'b0;
    sh_shift_s = 1'b0;
    sh_data_s  = pat_r;
    sh_cnt_s   = cnt_r;
    case (state_r)
      seq_pkg::IDLE: begin
        if (load_valid && load_ready_r) begin
          state_s   = seq_pkg::SEND;
          pat_s     = word_s;
          cnt_s     = word_cnt_s;
          rep_s     = load_rep;
          sh_load_s = 1'b1;
          sh_data_s = word_s;
          sh_cnt_s  = word_cnt_s;
        end else begin
          state_s = seq_pkg::IDLE;
        end
      end
      seq_pkg::SEND: begin
        if (!sh_last_s) begin
          sh_shift_s = 1'b1;
        end else if (rep_r != '0) begin
          if (GAP > 0) begin
            state_s    = seq_pkg::GAP;
            gap_s      = GAP_W'(GAP - 1);
            sh_shift_s = 1'b1;
          end else begin
            sh_load_s = 1'b1;
            rep_s     = rep_r - CNT_W'(1);
          end
        end else begin
          state_s    = seq_pkg::DONE;
          sh_shift_s = 1'b1;
        end
      end
      seq_pkg::GAP: begin
        if (gap_r == '0) begin
          state_s   = seq_pkg::SEND;
          sh_load_s = 1'b1;
          rep_s     = (rep_r != '0) ? (rep_r - CNT_W'(1)) : rep_r;
        end else begin
          gap_s = gap_r - GAP_W'(1);
        end
      end
      seq_pkg::DONE: begin
        state_s = seq_pkg::IDLE;
      end
      default: begin
        state_s = seq_pkg::IDLE;
      end
    endcase
  end

  // Control state and captured load context.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= seq_pkg::IDLE;
      rep_r   <= '0;
      gap_r   <= '0;
      pat_r   <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      rep_r   <= rep_s;
      gap_r   <= gap_s;
      pat_r   <= pat_s;
      cnt_r   <= cnt_s;
    end
  end

  // Status outputs registered from the next state so they align with ser_out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_ready_r <= 1'b1;
      ser_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      load_ready_r <= (state_s == seq_pkg::IDLE);
      ser_valid_r  <= (state_s == seq_pkg::SEND);
      busy_r       <= (state_s != seq_pkg::IDLE);
      done_r       <= (state_s == seq_pkg::DONE);
    end
  end

  seq_shift_reg #(
    .SW    (SW),
    .IDX_W (IDX_W)
  ) u_shift (
    .clk       (clk),
    .reset     (reset),
    .load      (sh_load_s),
    .shift     (sh_shift_s),
    .load_data (sh_data_s),
    .load_cnt  (sh_cnt_s),
    .msb       (sh_msb_s),
    .last      (sh_last_s)
  );

  assign load_ready = load_ready_r;
  assign ser_out    = sh_msb_s;
  assign ser_valid  = ser_valid_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: directed and random loads against a stream model.
module tb_seq_pattern_tx;

  localparam int TB_WIDTH = 8;
  localparam int TB_CNT_W = 4;
  localparam int TB_GAP   = 1;
`ifdef SEQ_PATTERN_TX_PARITY_EN
  localparam int TB_PAR = 1;
`else
  localparam int TB_PAR = 0;
`endif

  logic       clk;
  logic       reset;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] load_pattern;
  logic [3:0] load_len;
  logic [3:0] load_rep;
  logic       ser_out;
  logic       ser_valid;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  seq_pattern_tx #(
    .WIDTH (TB_WIDTH),
    .CNT_W (TB_CNT_W),
    .GAP   (TB_GAP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_pattern (load_pattern),
    .load_len     (load_len),
    .load_rep     (load_rep),
    .ser_out      (ser_out),
    .ser_valid    (ser_valid),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic scramble();
    load_valid   = 1'($urandom_range(0, 1));
    load_pattern = 8'($urandom);
    load_len     = 4'($urandom);
    load_rep     = 4'($urandom);
  endtask

  // Expects to be entered at a negedge with the DUT idle; leaves at the negedge of the next idle cycle.
  task automatic run(input logic [7:0] pat, input logic [3:0] len, input logic [3:0] rep);
    logic exp_v[$];
    logic exp_d[$];
    int   eff;
    logic par;
    eff = ((len == 4'd0) || (int'(len) > TB_WIDTH)) ? TB_WIDTH : int'(len);
    par = 1'b0;
    for (int k = 0; k < eff; k++) par = par ^ pat[k];
    for (int c = 0; c <= int'(rep); c++) begin
      for (int k = eff - 1; k >= 0; k--) begin
        exp_v.push_back(1'b1);
        exp_d.push_back(pat[k]);
      end
      if (TB_PAR == 1) begin
        exp_v.push_back(1'b1);
        exp_d.push_back(par);
      end
      if (c < int'(rep)) begin
        for (int g = 0; g < TB_GAP; g++) begin
          exp_v.push_back(1'b0);
          exp_d.push_back(1'b0);
        end
      end
    end

    load_valid   = 1'b1;
    load_pattern = pat;
    load_len     = len;
    load_rep     = rep;
    @(posedge clk); #1;
    for (int i = 0; i < exp_v.size(); i++) begin
      scramble();
      @(negedge clk);
      check("ser_valid", 32'(ser_valid), 32'(exp_v[i]));
      check("ser_out", 32'(ser_out), 32'(exp_d[i]));
      check("busy", 32'(busy), 32'd1);
      check("load_ready_busy", 32'(load_ready), 32'd0);
      check("done_early", 32'(done), 32'd0);
      @(posedge clk); #1;
    end
    // Hold a request through the done cycle; it must not be taken until idle.
    scramble();
    load_valid = 1'b1;
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd1);
    check("done_valid", 32'(ser_valid), 32'd0);
    check("done_out", 32'(ser_out), 32'd0);
    check("done_ready", 32'(load_ready), 32'd0);
    @(posedge clk); #1;
    load_valid = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(load_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_valid", 32'(ser_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rst_pat;
    rst_pat      = 8'hB3;
    reset        = 1'b1;
    load_valid   = 1'b0;
    load_pattern = 8'h00;
    load_len     = 4'd0;
    load_rep     = 4'd0;
    #3;
    check("rst_ser_out", 32'(ser_out), 32'd0);
    check("rst_ser_valid", 32'(ser_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(load_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(load_ready), 32'd1);

    run(8'hB3, 4'd8, 4'd0);
    run(8'h06, 4'd3, 4'd0);
    run(8'h06, 4'd3, 4'd2);
    run(8'hA5, 4'd0, 4'd0);
    run(8'h5C, 4'd12, 4'd1);
    run(8'hFF, 4'd1, 4'd3);

    // Reset part-way through a copy.
    load_valid   = 1'b1;
    load_pattern = rst_pat;
    load_len     = 4'd8;
    load_rep     = 4'd0;
    @(posedge clk); #1;
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("pre_rst_bit", 32'(ser_out), 32'(rst_pat[7 - i]));
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    check("mid_rst_out", 32'(ser_out), 32'd0);
    check("mid_rst_valid", 32'(ser_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_ready", 32'(load_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_done_after_rst", 32'(done), 32'd0);
      check("ready_after_rst", 32'(load_ready), 32'd1);
    end
    run(8'h96, 4'd8, 4'd0);

    for (int t = 0; t < 25; t++) begin
      run(8'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
